io_bus_master: RTL and testbench

//   CPU-side initiator for the memory-mapped IO bus (io_address/io_write_value/io_read_value/
//   io_write_en/io_read_en/io_data_size). Accepts one load/store request at a time from the core,

---
 rtl/io_bus_master_if.sv | 39 +++
 rtl/io_bus_master.sv | 188 ++++++++++++++++++
 tb/tb_io_bus_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/io_bus_master_if.sv
// io_bus_master_if
//   Groups the core-side request/response handshake and the memory-mapped
//   IO bus of io_bus_master into a single bundle.
//   master modport : the bus master (accepts requests, drives the IO bus)
//   slave  modport : the environment (core + IO peripheral side)
//   Signals:
//     req_valid/req_ready/req_write/req_addr/req_wdata/req_size  core request
//     resp_valid/resp_rdata/resp_err                             core response
//     io_address/io_write_value/io_write_en/io_read_en/
//     io_data_size/io_read_value                                 IO bus
interface io_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic [31:0] io_read_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, io_read_value,
    output req_ready, resp_valid, resp_rdata, resp_err,
           io_address, io_write_value, io_write_en, io_read_en, io_data_size
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, io_read_value,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           io_address, io_write_value, io_write_en, io_read_en, io_data_size
  );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master
//   CPU-side initiator for the memory-mapped IO bus. Takes one load/store
//   request at a time, drives the IO bus, waits out the peripheral read
//   latency and returns size-extended read data with a one-cycle response.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    master modport of io_bus_master_if (request, response, IO bus)
//   Parameter:
//     READ_LATENCY  cycles from io_address sampling to valid io_read_value (1..4)
module io_bus_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  io_bus_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q,       state_d;
  logic        ready_q,       ready_d;
  logic        write_en_q,    write_en_d;
  logic        read_en_q,     read_en_d;
  logic [2:0]  cnt_q,         cnt_d;
  logic [31:0] addr_q,        addr_d;
  logic [31:0] wdata_q,       wdata_d;
  logic [2:0]  size_q,        size_d;
  logic        write_q,       write_d;
  logic        resp_valid_q,  resp_valid_d;
  logic [31:0] resp_rdata_q,  resp_rdata_d;
  logic        resp_err_q,    resp_err_d;

  // Sizes 011, 110 and 111 have no load/store encoding.
  function automatic logic size_legal(input logic [2:0] size);
    logic ok;
    case (size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Sign/zero extension of right-aligned read data by funct3.
  function automatic logic [31:0] extend(input logic [2:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      3'b000:  r = {{24{data[7]}}, data[7:0]};
      3'b001:  r = {{16{data[15]}}, data[15:0]};
      3'b010:  r = data;
      3'b100:  r = {24'd0, data[7:0]};
      3'b101:  r = {16'd0, data[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    write_en_d   = write_en_q;
    read_en_d    = read_en_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    write_d      = write_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          write_d = bus.req_write;
          ready_d = 1'b0;
          if (!size_legal(bus.req_size)) begin
            // Illegal size answers immediately without touching the bus.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (bus.req_write) begin
            state_d    = S_WRITE;
            write_en_d = 1'b1;
          end else begin
            state_d   = S_READ;
            read_en_d = 1'b1;
            cnt_d     = 3'(READ_LATENCY);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        write_en_d   = 1'b0;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          // Peripheral data is valid in this cycle; capture on this edge.
          read_en_d    = 1'b0;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = extend(size_q, bus.io_read_value);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        ready_d      = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        ready_d      = 1'b1;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops strobes and any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      write_en_q   <= 1'b0;
      read_en_q    <= 1'b0;
      cnt_q        <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      size_q       <= 3'd0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      write_en_q   <= write_en_d;
      read_en_q    <= read_en_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The latched request feeds the bus directly, so it holds between transfers.
  assign bus.req_ready      = ready_q;
  assign bus.io_write_en    = write_en_q;
  assign bus.io_read_en     = read_en_q;
  assign bus.io_address     = addr_q;
  assign bus.io_write_value = wdata_q;
  assign bus.io_data_size   = size_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;

  // The request direction is latched for completeness of the captured request.
  logic unused_write_s;
  assign unused_write_s = write_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master
//   Directed bench for io_bus_master: one instance with READ_LATENCY=1 for
//   store/load/extension/error/reset cases and one with READ_LATENCY=3 for
//   back-to-back throughput. Each instance sees a one-register peripheral
//   that returns a bench-chosen value while io_read_en is high.
module tb_io_bus_master;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] periph1_data;
  logic [31:0] periph3_data;

  io_bus_master_if bus1 ();
  io_bus_master_if bus3 ();

  io_bus_master #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  io_bus_master #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered peripheral models.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus1.io_read_value <= 32'd0;
      bus3.io_read_value <= 32'd0;
    end else begin
      if (bus1.io_read_en) bus1.io_read_value <= periph1_data;
      if (bus3.io_read_en) bus3.io_read_value <= periph3_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size);
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    bus1.req_size  = size;
  endtask

  // Load through the L=1 instance and check the extended result at N+3.
  task automatic load1(input string tag, input logic [2:0] size, input logic [31:0] exp);
    drive1(1'b0, 32'h0000_0020, 32'd0, size);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, bus1.resp_valid}, 32'd1);
    check_eq({tag, "_rdata"}, bus1.resp_rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    periph1_data = 32'd0;
    periph3_data = 32'd0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'd0;
    bus1.req_wdata = 32'd0; bus1.req_size = 3'd0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = 32'd0;
    bus3.req_wdata = 32'd0; bus3.req_size = 3'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_ready", {31'd0, bus1.req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
    check_eq("rst_io_addr", bus1.io_address, 32'd0);
    check_eq("rst_io_strobes", {30'd0, bus1.io_write_en, bus1.io_read_en}, 32'd0);
    check_eq("rst_ready3", {31'd0, bus3.req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Store: strobe in N+1 only, response in N+2; request changes are ignored
    drive1(1'b1, 32'd4, 32'h0000_A5A5, 3'b010);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 32'd8;
    bus1.req_wdata = 32'hFFFF_FFFF;
    check_eq("sw_wen_n1", {31'd0, bus1.io_write_en}, 32'd1);
    check_eq("sw_addr_n1", bus1.io_address, 32'd4);
    check_eq("sw_value_n1", bus1.io_write_value, 32'h0000_A5A5);
    check_eq("sw_ready_n1", {31'd0, bus1.req_ready}, 32'd0);
    check_eq("sw_resp_n1", {31'd0, bus1.resp_valid}, 32'd0);
    @(negedge clk);
    check_eq("sw_wen_n2", {31'd0, bus1.io_write_en}, 32'd0);
    check_eq("sw_resp_n2", {31'd0, bus1.resp_valid}, 32'd1);
    check_eq("sw_err_n2", {31'd0, bus1.resp_err}, 32'd0);
    check_eq("sw_rdata_n2", bus1.resp_rdata, 32'd0);
    check_eq("sw_addr_n2", bus1.io_address, 32'd4);
    @(negedge clk);
    check_eq("sw_resp_n3", {31'd0, bus1.resp_valid}, 32'd0);
    check_eq("sw_ready_n3", {31'd0, bus1.req_ready}, 32'd1);

    // LW with L=1: read_en N+1..N+2, response N+3
    periph1_data = 32'h0000_8001;
    drive1(1'b0, 32'd1, 32'd0, 3'b010);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    check_eq("lw_ren_n1", {31'd0, bus1.io_read_en}, 32'd1);
    check_eq("lw_addr_n1", bus1.io_address, 32'd1);
    @(negedge clk);
    check_eq("lw_ren_n2", {31'd0, bus1.io_read_en}, 32'd1);
    check_eq("lw_resp_n2", {31'd0, bus1.resp_valid}, 32'd0);
    @(negedge clk);
    check_eq("lw_ren_n3", {31'd0, bus1.io_read_en}, 32'd0);
    check_eq("lw_resp_n3", {31'd0, bus1.resp_valid}, 32'd1);
    check_eq("lw_rdata_n3", bus1.resp_rdata, 32'h0000_8001);
    @(negedge clk);
    check_eq("lw_rdata_clr", bus1.resp_rdata, 32'd0);

    // Extension of 0x00008080 by size
    periph1_data = 32'h0000_8080;
    load1("lh", 3'b001, 32'hFFFF_8080);
    load1("lhu", 3'b101, 32'h0000_8080);
    load1("lb", 3'b000, 32'hFFFF_FF80);
    load1("lbu", 3'b100, 32'h0000_0080);

    // Illegal size: immediate error response, no bus strobe
    drive1(1'b1, 32'd12, 32'h1234_5678, 3'b011);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    check_eq("err_resp_n1", {31'd0, bus1.resp_valid}, 32'd1);
    check_eq("err_flag_n1", {31'd0, bus1.resp_err}, 32'd1);
    check_eq("err_rdata_n1", bus1.resp_rdata, 32'd0);
    check_eq("err_strobes_n1", {30'd0, bus1.io_write_en, bus1.io_read_en}, 32'd0);
    @(negedge clk);
    check_eq("err_strobes_n2", {30'd0, bus1.io_write_en, bus1.io_read_en}, 32'd0);
    check_eq("err_flag_n2", {31'd0, bus1.resp_err}, 32'd0);
    check_eq("err_ready_n2", {31'd0, bus1.req_ready}, 32'd1);

    // Reset in the middle of a read: strobe drops at once, no response later
    drive1(1'b0, 32'h0000_0010, 32'd0, 3'b010);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    check_eq("mrst_ren_before", {31'd0, bus1.io_read_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_ren_async", {31'd0, bus1.io_read_en}, 32'd0);
    check_eq("mrst_resp_async", {31'd0, bus1.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mrst_no_resp", {31'd0, bus1.resp_valid}, 32'd0);
    end
    check_eq("mrst_ready", {31'd0, bus1.req_ready}, 32'd1);
    check_eq("mrst_io_addr", bus1.io_address, 32'd0);
    check_eq("mrst_io_size", {29'd0, bus1.io_data_size}, 32'd0);
    check_eq("mrst_rdata", bus1.resp_rdata, 32'd0);

    // Back-to-back loads with L=3 and req_valid held high
    periph3_data = 32'hCAFE_0042;
    bus3.req_valid = 1'b1;
    bus3.req_write = 1'b0;
    bus3.req_addr  = 32'd3;
    bus3.req_size  = 3'b010;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_ready_n%0d", k), {31'd0, bus3.req_ready},
               (k == 6 || k == 12) ? 32'd1 : 32'd0);
      check_eq($sformatf("b2b_resp_n%0d", k), {31'd0, bus3.resp_valid},
               (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 5 || k == 11) check_eq($sformatf("b2b_rdata_n%0d", k), bus3.resp_rdata,
                                      32'hCAFE_0042);
      if (k == 7) bus3.req_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
